bcd_to_bin_32: RTL and testbench

//  Sequential packed-BCD to binary converter: the consumer side of the 8-digit BCD count bus.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_mac10.sv | 23 ++
 rtl/bcd_to_bin_32.sv | 126 ++++++++++++
 tb/tb_bcd_to_bin_32.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared BCD constants and converter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int                      BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0]  BCD_MAX     = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_mac10.sv
// ============================================================================
// Module  : bcd_mac10
// Brief   : Combinational acc*10 + digit, truncated to OUT_W bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int OUT_W = 27
) (
   input  logic [OUT_W-1:0]       acc,
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [OUT_W-1:0]       result
);

   // Shift-add form keeps the multiply-by-ten as two adders.
   assign result = (acc << 3) + (acc << 1) + OUT_W'(digit);

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_32.sv
// ============================================================================
// Module  : bcd_to_bin_32
// Brief   : Sequential packed-BCD to binary converter, MS digit first.
//           Optional invalid-digit flag (port err) when BCD_CHECK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_32
   import bcd_pkg::*;
#(
   parameter int NDIG  = 8,
   parameter int OUT_W = 27
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [BCD_DIGIT_W*NDIG-1:0] din,
   output logic                        busy,
   output logic                        done,
   output logic [OUT_W-1:0]            dout
`ifdef BCD_CHECK_EN
   ,
   output logic                        err
`endif
);

   localparam int                 c_din_w = BCD_DIGIT_W * NDIG;
   localparam int                 c_cnt_w = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(NDIG - 1);

   state_t                   r_state;
   state_t                   w_next;
   logic [c_din_w-1:0]       r_sreg;
   logic [OUT_W-1:0]         r_acc;
   logic [OUT_W-1:0]         r_dout;
   logic [OUT_W-1:0]         w_mac;
   logic [c_cnt_w-1:0]       r_cnt;
   logic                     r_busy;
   logic                     r_done;
   logic [BCD_DIGIT_W-1:0]   w_digit;
   logic                     w_last;
   logic                     w_accept;

   assign w_digit  = r_sreg[c_din_w-1 -: BCD_DIGIT_W];
   assign w_last   = (r_cnt == c_last);
   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));

   bcd_mac10 #(
      .OUT_W (OUT_W)
   ) u_mac (
      .acc    (r_acc),
      .digit  (w_digit),
      .result (w_mac)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_RUN;
         ST_RUN:  if (w_last) w_next = ST_FIN;
         ST_FIN:  w_next = start ? ST_RUN : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // busy/done come from flops loaded with the next-state decode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == ST_RUN);
         r_done  <= (w_next == ST_FIN);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sreg <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_dout <= '0;
      end else if (w_accept) begin
         r_sreg <= din;
         r_acc  <= '0;
         r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
         r_acc  <= w_mac;
         r_sreg <= r_sreg << BCD_DIGIT_W;
         r_cnt  <= r_cnt + c_cnt_w'(1);
         if (w_last) r_dout <= w_mac;
      end
   end

`ifdef BCD_CHECK_EN
   logic r_flag;
   logic r_err;
   logic w_bad;

   assign w_bad = (w_digit > BCD_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_flag <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_flag <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_flag <= r_flag | w_bad;
         if (w_last) r_err <= r_flag | w_bad;
      end
   end

   assign err = r_err;
`endif

   assign busy = r_busy;
   assign done = r_done;
   assign dout = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_32.sv
// ============================================================================
// Module  : tb_bcd_to_bin_32
// Brief   : Randomized self-checking bench for bcd_to_bin_32 (BCD_CHECK_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_32;

   localparam int NDIG  = 8;
   localparam int OUT_W = 27;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic              start   = 1'b0;
   logic [31:0]       din     = '0;
   logic              busy;
   logic              done;
   logic [OUT_W-1:0]  dout;
`ifdef BCD_CHECK_EN
   logic              err;
   bit                exp_err = 1'b0;
`endif

   int               n_cmp    = 0;
   int               n_bad    = 0;
   logic [OUT_W-1:0] exp_dout = '0;
   logic [31:0]      chain_v [0:5];

   always #5 clk = ~clk;

   bcd_to_bin_32 #(
      .NDIG  (NDIG),
      .OUT_W (OUT_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .din     (din),
      .busy    (busy),
      .done    (done),
      .dout    (dout)
`ifdef BCD_CHECK_EN
      ,
      .err     (err)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Decimal value of the digit string, each nibble taken at face value.
   function automatic logic [OUT_W-1:0] ref_bin(input logic [31:0] w);
      longint unsigned a = 0;
      for (int i = NDIG - 1; i >= 0; i--) a = a * 10 + 64'(w[4*i +: 4]);
      return a[OUT_W-1:0];
   endfunction

   function automatic bit ref_err(input logic [31:0] w);
      bit e = 1'b0;
      for (int i = 0; i < NDIG; i++) if (w[4*i +: 4] > 4'd9) e = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] rand_bcd();
      logic [31:0] w = '0;
      for (int i = 0; i < NDIG; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      return w;
   endfunction

   // Entered just after the negedge where start=1/din=v were driven.
   task automatic observe(input logic [31:0] v, input bit poke, input bit chain,
                          input logic [31:0] vnext);
      int edges;
      int busy_n;
      @(negedge clk);
      start  = 1'b0;
      din    = $urandom;
      edges  = 1;
      busy_n = 0;
      while (!done && edges < 20) begin
         if (busy) busy_n++;
         if (edges == 4) check_eq("dout_hold_run", 32'(dout), 32'(exp_dout));
         if (poke && edges == 3) begin
            start = 1'b1;
            din   = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      check_eq("latency", edges, 9);
      check_eq("busy_cycles", busy_n, 8);
      exp_dout = ref_bin(v);
      check_eq("dout", 32'(dout), 32'(exp_dout));
`ifdef BCD_CHECK_EN
      exp_err = ref_err(v);
      check_eq("err", 32'(err), 32'(exp_err));
`endif
      if (chain) begin
         start = 1'b1;
         din   = vnext;
      end else begin
         @(negedge clk);
         check_eq("done_one_cycle", 32'(done), 0);
         check_eq("busy_idle", 32'(busy), 0);
         check_eq("dout_held", 32'(dout), 32'(exp_dout));
`ifdef BCD_CHECK_EN
         check_eq("err_held", 32'(err), 32'(exp_err));
`endif
      end
   endtask

   task automatic conv(input logic [31:0] v);
      @(negedge clk);
      start = 1'b1;
      din   = v;
      observe(v, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] va;
      logic [31:0] vb;

      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_dout", 32'(dout), 0);
`ifdef BCD_CHECK_EN
      check_eq("rst_err", 32'(err), 0);
`endif
      reset_n = 1'b1;

      conv(32'h0000_0000);
      conv(32'h1234_5678);
      check_eq("dout_12345678", 32'(dout), 32'h00BC_614E);
      conv(32'h9999_9999);
      check_eq("dout_99999999", 32'(dout), 32'h05F5_E0FF);

      // START during RUN ignored, then START in FIN chains a second conversion.
      va = rand_bcd();
      vb = rand_bcd();
      @(negedge clk);
      start = 1'b1;
      din   = va;
      observe(va, 1'b1, 1'b1, vb);
      observe(vb, 1'b0, 1'b0, 32'h0);

      // Asynchronous abort in the middle of a conversion.
      @(negedge clk);
      start = 1'b1;
      din   = 32'h8765_4321;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_dout", 32'(dout), 0);
      check_eq("abort_done", 32'(done), 0);
      exp_dout = '0;
`ifdef BCD_CHECK_EN
      check_eq("abort_err", 32'(err), 0);
      exp_err = 1'b0;
`endif
      repeat (2) begin
         @(negedge clk);
         check_eq("abort_no_done", 32'(done), 0);
      end
      reset_n = 1'b1;
      conv(rand_bcd());

      conv(32'h0000_000A);
      check_eq("dout_0A", 32'(dout), 10);
      conv(32'h0000_0010);
      check_eq("dout_10", 32'(dout), 10);

      for (int i = 0; i < 25; i++) conv(rand_bcd());
      for (int i = 0; i < 8; i++) conv($urandom);

      for (int i = 0; i < 6; i++) chain_v[i] = (i % 2 == 0) ? rand_bcd() : $urandom;
      @(negedge clk);
      start = 1'b1;
      din   = chain_v[0];
      for (int i = 0; i < 6; i++)
         observe(chain_v[i], 1'b0, (i < 5), (i < 5) ? chain_v[(i + 1) % 6] : 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
